pcileech_com_tx_pack: RTL and testbench

- Transmit-direction packer between the FIFO controller and the buffered communication device.
- Accepts 256-bit result frames from the FIFO controller's com_din / wr_en / ready path.
- Serialises each frame into eight 32-bit words for the FT601 write path, lowest word first.
- Single clock domain (clk); the output feeds the clock-crossing FIFO inside the communication block.

---
 rtl/pcileech_com_tx_pack.sv | 98 +++++++++
 tb/tb_pcileech_com_tx_pack.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_com_tx_pack.sv
// Packs 256-bit result frames into eight 32-bit words (lowest first) for the FT601 write path.
// Optional filler skipping is compiled in with `define PCILEECH_COM_TX_SKIP_FILLER_EN.
module pcileech_com_tx_pack #(
  parameter logic [31:0] FILLER_WORD = 32'h66665555,
  parameter int          CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [255:0]         in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [31:0]          out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] word_count
);

  logic [255:0]         s_q, s_d, h_q, h_d;
  logic                 sv_q, sv_d, hv_q, hv_d;
  logic [2:0]           idx_q, idx_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [31:0] cur_word;
  logic        is_fill, adv, xfer, acc, last;

  assign cur_word = s_q[{idx_q, 5'd0} +: 32];

`ifdef PCILEECH_COM_TX_SKIP_FILLER_EN
  assign is_fill = (cur_word == FILLER_WORD);
`else
  logic unused_filler;
  assign unused_filler = ^FILLER_WORD;
  assign is_fill       = 1'b0;
`endif

  // Filler words are dropped without waiting on the sink.
  assign adv  = sv_q & (out_ready | is_fill);
  assign xfer = sv_q & ~is_fill & out_ready;
  assign acc  = in_valid & ~hv_q;
  assign last = adv & (idx_q == 3'd7);

  assign in_ready   = ~hv_q;
  assign out_data   = cur_word;
  assign out_valid  = sv_q & ~is_fill;
  assign busy       = sv_q | hv_q;
  assign word_count = cnt_q;

  always_comb begin
    s_d   = s_q;
    h_d   = h_q;
    sv_d  = sv_q;
    hv_d  = hv_q;
    idx_d = idx_q;
    cnt_d = xfer ? cnt_q + 1'b1 : cnt_q;
    if (adv) begin
      if (idx_q != 3'd7) begin
        idx_d = idx_q + 3'd1;
      end else if (hv_q) begin
        s_d   = h_q;
        idx_d = 3'd0;
        hv_d  = 1'b0;
      end else begin
        sv_d  = 1'b0;
      end
    end
    // acc implies hv_q = 0, so it never collides with the H->S reload.
    if (acc) begin
      if (!sv_q || last) begin
        s_d   = in_data;
        idx_d = 3'd0;
        sv_d  = 1'b1;
      end else begin
        h_d   = in_data;
        hv_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= '0;
      h_q   <= '0;
      sv_q  <= 1'b0;
      hv_q  <= 1'b0;
      idx_q <= 3'd0;
      cnt_q <= '0;
    end else begin
      s_q   <= s_d;
      h_q   <= h_d;
      sv_q  <= sv_d;
      hv_q  <= hv_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pcileech_com_tx_pack.sv
// Directed self-checking bench for pcileech_com_tx_pack.
module tb_pcileech_com_tx_pack;

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic [31:0]  wc;

  logic         in_ready4, out_valid4, busy4;
  logic [31:0]  out_data4;
  logic [3:0]   wc4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pcileech_com_tx_pack dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .word_count(wc)
  );

  pcileech_com_tx_pack #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_ready(out_ready), .busy(busy4),
    .word_count(wc4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] mk(logic [31:0] base);
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[32*k +: 32] = base + 32'(k);
    return r;
  endfunction

  function automatic logic [31:0] sexp(logic [31:0] base, int j);
    return base + 32'h100 * 32'(j / 8) + 32'(j % 8);
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_data = mk(32'hDEAD0000); out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (wc !== 32'd0) begin failures++; $display("FAIL reset_count: got %0d want 0", wc); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_ignores_in_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_single();
    in_data = mk(32'h0); in_valid = 1'b1; out_ready = 1'b1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(k)) begin
        failures++; $display("FAIL single_word%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, 32'(k));
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL single_idle: got v=%b busy=%b want 0 0", out_valid, busy); end
    checks++; if (wc !== 32'd8) begin failures++; $display("FAIL single_count: got %0d want 8", wc); end
  endtask

  task automatic test_back_to_back();
    int fi, j;
    bit started, saw_low, reasserted, acc;
    fi = 0; j = 0; started = 0; saw_low = 0; reasserted = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 60 && j < 24; c++) begin
      in_valid = (fi < 3);
      in_data  = mk(32'h1000 + 32'h100 * 32'(fi));
      if (!in_ready) saw_low = 1;
      else if (saw_low) reasserted = 1;
      if (out_valid) begin
        checks++;
        if (out_data !== sexp(32'h1000, j)) begin
          failures++; $display("FAIL b2b_word%0d: got %h want %h", j, out_data, sexp(32'h1000, j));
        end
        j++; started = 1;
      end else if (started) begin
        checks++; failures++; $display("FAIL b2b_bubble: got out_valid=0 at word %0d want 1", j);
      end
      acc = in_valid & in_ready;
      tick();
      if (acc) fi++;
    end
    in_valid = 1'b0;
    checks++; if (j != 24) begin failures++; $display("FAIL b2b_words: got %0d want 24", j); end
    checks++; if (!(saw_low && reasserted)) begin failures++; $display("FAIL b2b_in_ready: got low=%b reassert=%b want 1 1", saw_low, reasserted); end
    checks++; if (wc !== 32'd32) begin failures++; $display("FAIL b2b_count: got %0d want 32", wc); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy: got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int fi, j;
    bit held_v, acc;
    logic [31:0] held;
    fi = 0; j = 0; held_v = 0; held = '0;
    for (int c = 0; c < 100 && j < 16; c++) begin
      out_ready = (c % 4 == 0) || (c % 4 == 3);
      in_valid  = (fi < 2);
      in_data   = mk(32'h2000 + 32'h100 * 32'(fi));
      if (fi == 2 && j < 8) begin
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_full: got %b want 0", in_ready); end
      end
      if (out_valid) begin
        if (held_v) begin
          checks++; if (out_data !== held) begin failures++; $display("FAIL bp_stable: got %h want %h", out_data, held); end
        end
        if (out_ready) begin
          checks++;
          if (out_data !== sexp(32'h2000, j)) begin
            failures++; $display("FAIL bp_word%0d: got %h want %h", j, out_data, sexp(32'h2000, j));
          end
          j++; held_v = 0;
        end else begin
          held_v = 1; held = out_data;
        end
      end
      acc = in_valid & in_ready;
      tick();
      if (acc) fi++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++; if (j != 16) begin failures++; $display("FAIL bp_words: got %0d want 16", j); end
    checks++; if (wc !== 32'd48) begin failures++; $display("FAIL bp_count: got %0d want 48", wc); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_data = mk(32'h3000); in_valid = 1'b1;
    tick();
    in_data = mk(32'h3100);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    checks++; if (in_ready !== 1'b0 || out_data !== 32'h3004) begin
      failures++; $display("FAIL mid_pre_reset: got ready=%b d=%h want 0 3004", in_ready, out_data);
    end
    rst = 1'b1; in_valid = 1'b1; in_data = mk(32'h3F00);
    tick();
    rst = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL mid_reset_state: got v=%b ready=%b busy=%b want 0 1 0", out_valid, in_ready, busy);
    end
    checks++; if (wc !== 32'd0) begin failures++; $display("FAIL mid_reset_count: got %0d want 0", wc); end
    in_data = mk(32'h3200); in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h3200 + 32'(k)) begin
        failures++; $display("FAIL mid_new_word%0d: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, 32'h3200 + 32'(k));
      end
      tick();
    end
    checks++; if (wc !== 32'd8 || busy !== 1'b0) begin failures++; $display("FAIL mid_new_done: got count=%0d busy=%b want 8 0", wc, busy); end
  endtask

  task automatic test_wrap();
    int fi, xfer;
    bit acc;
    rst = 1'b1; in_valid = 1'b0; tick(); rst = 1'b0;
    fi = 0; xfer = 0;
    for (int c = 0; c < 80 && xfer < 20; c++) begin
      out_ready = 1'b1;
      in_valid  = (fi < 3);
      in_data   = mk(32'h4000 + 32'h100 * 32'(fi));
      if (out_valid) xfer++;
      acc = in_valid & in_ready;
      tick();
      if (acc) fi++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (wc !== 32'd20) begin failures++; $display("FAIL wrap_count32: got %0d want 20", wc); end
    checks++; if (wc4 !== 4'd4) begin failures++; $display("FAIL wrap_count4: got %0d want 4", wc4); end
    rst = 1'b1; tick(); rst = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_filler();
    logic [31:0] w [8];
    logic [31:0] got [16];
    int n;
    w = '{32'h66665555, 32'h0000000A, 32'h66665555, 32'h66665555,
          32'h66665555, 32'h66665555, 32'h66665555, 32'h0000000B};
    for (int k = 0; k < 8; k++) in_data[32*k +: 32] = w[k];
    n = 0; out_ready = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (out_valid && n < 16) begin got[n] = out_data; n++; end
      tick();
    end
`ifdef PCILEECH_COM_TX_SKIP_FILLER_EN
    checks++; if (n != 2) begin failures++; $display("FAIL filler_n: got %0d want 2", n); end
    checks++; if (n >= 2 && (got[0] !== 32'hA || got[1] !== 32'hB)) begin
      failures++; $display("FAIL filler_words: got %h %h want a b", got[0], got[1]);
    end
    checks++; if (wc !== 32'd2) begin failures++; $display("FAIL filler_count: got %0d want 2", wc); end
`else
    checks++; if (n != 8) begin failures++; $display("FAIL filler_n: got %0d want 8", n); end
    for (int k = 0; k < 8 && k < n; k++) begin
      checks++; if (got[k] !== w[k]) begin failures++; $display("FAIL filler_word%0d: got %h want %h", k, got[k], w[k]); end
    end
    checks++; if (wc !== 32'd8) begin failures++; $display("FAIL filler_count: got %0d want 8", wc); end
`endif
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL filler_busy: got %b want 0", busy); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_filler();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
